// File: rtl/pwm_dac_scheduler.sv
// pwm_dac_scheduler: round-robin sharing of a PWM DAC code input.
// New codes land only on a frame boundary and are held for a minimum number of frames.
module pwm_dac_scheduler #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 12,
    parameter int HOLD_FRAMES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] code_in,
    output logic [WIDTH-1:0]      dac_code,
    output logic                  dac_load,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        WAIT_FRAME,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     arb_idx;
    logic [PW-1:0]     idx;
    logic              arb_hit;
    logic [NREQ-1:0]   arb_oh;
    logic [NREQ-1:0]   stage_oh;
    logic [WIDTH-1:0]  staged;
    logic [7:0]        hold_cnt;

    // Round-robin search: first set req bit after ptr, wrapping.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = '0;
        arb_oh  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!arb_hit && req[idx]) begin
                arb_hit = 1'b1;
                arb_idx = idx;
            end
        end
        if (arb_hit) begin
            arb_oh[arb_idx] = 1'b1;
        end
    end

    // Next-state logic; ARB with no surviving request falls back to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx = ARB;
                end
            end
            ARB: begin
                state_nx = arb_hit ? WAIT_FRAME : IDLE;
            end
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == 8'd0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Staging, DAC output register, pulses and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= PW'(NREQ - 1);
            staged   <= '0;
            stage_oh <= '0;
            dac_code <= '0;
            dac_load <= 1'b0;
            gnt      <= '0;
            ack      <= '0;
            hold_cnt <= 8'd0;
        end else begin
            dac_load <= 1'b0;
            ack      <= '0;
            if (state == ARB && arb_hit) begin
                staged   <= code_in[int'(arb_idx)*WIDTH +: WIDTH];
                ptr      <= arb_idx;
                stage_oh <= arb_oh;
                ack      <= arb_oh;
            end
            if (state == WAIT_FRAME && frame_start) begin
                dac_code <= staged;
                gnt      <= stage_oh;
                dac_load <= 1'b1;
                hold_cnt <= 8'(HOLD_FRAMES - 1);
            end
            if (state == HOLD && hold_cnt != 8'd0 && frame_start) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
